nonce_sweep_ctrl: RTL

Sequencer that drives the single-block SHA-256 core through a nonce range for mining. It latches a 512-bit block template and inserts each nonce into a fixed 32-bit word. For each nonce it starts the core, waits for done, and checks the digest for a required count of leading zero bits. It sits between the Avalon register front-end and sha256_module, replacing per-hash software start/poll.

---
 rtl/sweep_pkg.sv | 35 +++
 rtl/lz_count256.sv | 27 ++
 rtl/nonce_sweep_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/sweep_pkg.sv
// -----------------------------------------------------------------------------
// sweep_pkg
//   Shared definitions for the nonce sweep controller.
//   - BLOCK_W / DIGEST_W / NONCE_W : widths of the SHA-256 block, the digest
//     and the nonce.
//   - sweep_state_e : controller states (IDLE, ISSUE, WAIT, CHECK, DRAIN).
//   - insert_nonce() : overwrite one 32-bit word of a block with a nonce.
// -----------------------------------------------------------------------------
package sweep_pkg;

    localparam int BLOCK_W  = 512;
    localparam int DIGEST_W = 256;
    localparam int NONCE_W  = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        DRAIN = 3'd4
    } sweep_state_e;

    // Word idx occupies block[32*idx+31 : 32*idx].
    function automatic logic [BLOCK_W-1:0] insert_nonce(
        input logic [BLOCK_W-1:0] block,
        input int unsigned        idx,
        input logic [NONCE_W-1:0] nonce
    );
        logic [BLOCK_W-1:0] b;
        b = block;
        b[NONCE_W*idx +: NONCE_W] = nonce;
        return b;
    endfunction

endpackage

// File: rtl/lz_count256.sv
// -----------------------------------------------------------------------------
// lz_count256
//   Combinational leading-zero count of a 256-bit vector, counted from bit 255
//   downward. An all-zero input yields 256.
//   Ports:
//     value  in  256  vector to examine
//     count  out 9    number of leading zero bits (0-256)
// -----------------------------------------------------------------------------
module lz_count256
    import sweep_pkg::*;
(
    input  logic [DIGEST_W-1:0] value,
    output logic [8:0]          count
);

    // Scanning upward lets the highest set bit overwrite any lower one, so no
    // early exit is needed.
    always_comb begin
        count = 9'd256;
        for (int i = 0; i < DIGEST_W; i++) begin
            if (value[i]) begin
                count = 9'(DIGEST_W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/nonce_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// nonce_sweep_ctrl
//   Sweeps a nonce range through a single-block SHA-256 core. A job latches a
//   512-bit template, first/last nonce and the required number of leading zero
//   bits. For every nonce the template word NONCE_WORD is replaced by the
//   nonce, the core is started, its digest is captured and tested. The job
//   ends on the first hit, after the last nonce, on abort, or (optionally) on
//   a core_done timeout.
//
//   Parameters:
//     NONCE_WORD   template word (0-15) replaced by the nonce
//     WDOG_CYCLES  core_done timeout in cycles (only with WATCHDOG_EN)
//
//   Build option:
//     WATCHDOG_EN  when defined, a timeout counter runs in WAIT and DRAIN and
//                  raises core_fault on expiry; otherwise core_fault is 0 and
//                  the controller waits for core_done indefinitely.
//
//   Ports:
//     clk, reset            clock; synchronous active-high reset
//     cfg_valid/cfg_ready   job request handshake, see below
//     cfg_block             512-bit block template
//     cfg_nonce_start/end   first and last (inclusive) nonce
//     cfg_zero_bits         required leading zero bits (clamped to 256)
//     abort                 cancel the running job
//     core_start            one-cycle start pulse to the core
//     core_block            template with nonce inserted
//     core_digest/core_done core result and its one-cycle valid pulse
//     busy                  controller not idle
//     found/exhausted       sticky job outcome flags
//     core_fault            sticky watchdog expiry flag
//     result_nonce          nonce of the hit, or last nonce tried
//     result_digest         digest of the last nonce evaluated
//     hashes_done           digests evaluated in the current job
//
//   Handshake: a job is accepted on a rising clk edge where cfg_valid and
//   cfg_ready are both high; cfg_ready is high only in IDLE, and requests
//   made while busy are dropped, never queued.
// -----------------------------------------------------------------------------
module nonce_sweep_ctrl
    import sweep_pkg::*;
#(
    parameter int NONCE_WORD  = 3,
    parameter int WDOG_CYCLES = 4096
)
(
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [BLOCK_W-1:0]  cfg_block,
    input  logic [NONCE_W-1:0]  cfg_nonce_start,
    input  logic [NONCE_W-1:0]  cfg_nonce_end,
    input  logic [8:0]          cfg_zero_bits,
    input  logic                abort,
    output logic                core_start,
    output logic [BLOCK_W-1:0]  core_block,
    input  logic [DIGEST_W-1:0] core_digest,
    input  logic                core_done,
    output logic                busy,
    output logic                found,
    output logic                exhausted,
    output logic                core_fault,
    output logic [NONCE_W-1:0]  result_nonce,
    output logic [DIGEST_W-1:0] result_digest,
    output logic [31:0]         hashes_done
);

    localparam logic [2:0] ST_IDLE  = IDLE;
    localparam logic [2:0] ST_ISSUE = ISSUE;
    localparam logic [2:0] ST_WAIT  = WAIT;
    localparam logic [2:0] ST_CHECK = CHECK;
    localparam logic [2:0] ST_DRAIN = DRAIN;

    logic [2:0]          state;
    logic [BLOCK_W-1:0]  tmpl_q;
    logic [NONCE_W-1:0]  nonce_q;
    logic [NONCE_W-1:0]  end_q;
    logic [8:0]          zero_bits_q;
    logic                found_q;
    logic                exhausted_q;
    logic [NONCE_W-1:0]  result_nonce_q;
    logic [DIGEST_W-1:0] result_digest_q;
    logic [31:0]         hashes_q;

    logic [8:0]          lz;
    logic                hit;
    logic [8:0]          zb_clamped;
    logic                accept;
    logic                wdog_fire;

    assign accept     = (state == ST_IDLE) && cfg_valid;
    assign zb_clamped = (cfg_zero_bits > 9'd256) ? 9'd256 : cfg_zero_bits;

    // The test runs in CHECK on the digest registered at core_done, keeping
    // the 256-bit count off the core_digest input path.
    lz_count256 u_lz (
        .value (result_digest_q),
        .count (lz)
    );
    assign hit = (lz >= zero_bits_q);

`ifdef WATCHDOG_EN
    logic [31:0] wdog_cnt;
    logic        fault_q;
    logic        wdog_restart;

    // Expiry only counts when nothing else ends the wait this cycle:
    // a done or an abort in WAIT take precedence.
    assign wdog_fire = (wdog_cnt == 32'(WDOG_CYCLES - 1)) && !core_done &&
                       (((state == ST_WAIT) && !abort) || (state == ST_DRAIN));

    // Counter restarts on entry to WAIT (from ISSUE) and to DRAIN (from WAIT).
    assign wdog_restart = ((state == ST_ISSUE) && !abort) ||
                          ((state == ST_WAIT) && abort && !core_done);

    always_ff @(posedge clk) begin
        if (reset) begin
            wdog_cnt <= '0;
            fault_q  <= 1'b0;
        end else begin
            if (wdog_restart) begin
                wdog_cnt <= '0;
            end else if ((state == ST_WAIT) || (state == ST_DRAIN)) begin
                wdog_cnt <= wdog_cnt + 32'd1;
            end

            if (accept) begin
                fault_q <= 1'b0;
            end else if (wdog_fire) begin
                fault_q <= 1'b1;
            end
        end
    end

    assign core_fault = fault_q;
`else
    assign wdog_fire  = 1'b0;
    assign core_fault = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_IDLE;
            tmpl_q          <= '0;
            nonce_q         <= '0;
            end_q           <= '0;
            zero_bits_q     <= '0;
            found_q         <= 1'b0;
            exhausted_q     <= 1'b0;
            result_nonce_q  <= '0;
            result_digest_q <= '0;
            hashes_q        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cfg_valid) begin
                        tmpl_q      <= cfg_block;
                        nonce_q     <= cfg_nonce_start;
                        end_q       <= cfg_nonce_end;
                        zero_bits_q <= zb_clamped;
                        found_q     <= 1'b0;
                        exhausted_q <= 1'b0;
                        hashes_q    <= '0;
                        state       <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    state <= abort ? ST_IDLE : ST_WAIT;
                end

                ST_WAIT: begin
                    if (abort) begin
                        // A done arriving with the abort is already the
                        // outstanding result, so there is nothing to drain.
                        state <= core_done ? ST_IDLE : ST_DRAIN;
                    end else if (core_done) begin
                        result_digest_q <= core_digest;
                        hashes_q        <= hashes_q + 32'd1;
                        state           <= ST_CHECK;
                    end else if (wdog_fire) begin
                        state <= ST_IDLE;
                    end
                end

                ST_CHECK: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else begin
                        result_nonce_q <= nonce_q;
                        // A hit on the last nonce reports found only.
                        if (hit) begin
                            found_q <= 1'b1;
                            state   <= ST_IDLE;
                        end else if (nonce_q == end_q) begin
                            exhausted_q <= 1'b1;
                            state       <= ST_IDLE;
                        end else begin
                            nonce_q <= nonce_q + 32'd1;
                            state   <= ST_ISSUE;
                        end
                    end
                end

                ST_DRAIN: begin
                    if (core_done || wdog_fire) begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cfg_ready     = (state == ST_IDLE);
    assign busy          = (state != ST_IDLE);
    assign core_start    = (state == ST_ISSUE);
    // nonce_q only changes in CHECK, so the block is stable ISSUE..WAIT.
    assign core_block    = insert_nonce(tmpl_q, NONCE_WORD, nonce_q);
    assign found         = found_q;
    assign exhausted     = exhausted_q;
    assign result_nonce  = result_nonce_q;
    assign result_digest = result_digest_q;
    assign hashes_done   = hashes_q;

endmodule
